dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Dot-product controller that sequences the `dsp` slice as a multiply-accumulator. Operand pairs arrive over a valid/ready stream. The sequencer clears the slice, streams `len` operand pairs into it with the post-adder in P-feedback mode, flushes the pipeline, and returns one 48-bit result per job. It sits between a job master and a single `dsp` instance, and owns all of that instance's control inputs.

## Interface
- `LEN_W`, 8: width of the job-length field and the beat counter.
- `DSP_LAT`, 3: number of enabled clock edges from operand capture at A/B to the product's contribution being visible on `P` (A/B reg, M reg, P reg).

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `start` in 1: job request, sampled in IDLE only.
- `len` in LEN_W: number of operand pairs in the job, sampled with `start`.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: sequencer accepts a beat.
- `a_in` in 18: multiplicand, unsigned.
- `b_in` in 18: multiplier, unsigned.
- `d_in` in 18: pre-adder operand, used only with `DSP_MAC_PREADD_EN`.
- `busy` out 1: high whenever the state is not IDLE.
- `res_valid` out 1: one-cycle result strobe.
- `res` out 48: accumulated result, held until the next result.
- `res_ovf` out 1: sticky post-adder carry-out seen during the job; valid with `res`.
- `dsp_a`, `dsp_b`, `dsp_d` out 18: to the DSP A, B and D inputs.
- `dsp_opmode` out 8: to the DSP OPMODE input.
- `dsp_ce` out 1: drives every CE of the DSP.
- `dsp_rst` out 1: drives every RST of the DSP.
- `dsp_p` in 48: from the DSP P output.
- `dsp_carryout` in 1: from the DSP CARRYOUT output.

## Operation
- The FSM has five states: IDLE, CLR, FEED, DRAIN, DONE.
- **IDLE.** `start` moves the FSM to CLR and latches `len` into the beat counter. `start` is ignored in every other state.
- **CLR** lasts one cycle.
  - `dsp_rst` = 1 and `dsp_ce` = 0.
  - `res_ovf` is cleared.
  - Next state is FEED if `len` != 0, else DRAIN.
- **FEED.**
  - `in_ready` = 1.
  - `dsp_ce` = `in_valid`. When `in_valid` is low, the whole DSP pipeline freezes, which preserves alignment.
  - On an accepted beat, `dsp_a`/`dsp_b`/`dsp_d` pass `a_in`/`b_in`/`d_in` combinationally and the counter decrements. In all other cycles they are 0.
  - The last accepted beat moves the FSM to DRAIN.
- **DRAIN** lasts exactly `DSP_LAT` cycles.
  - `dsp_ce` = 1 and operands are 0, so zero products flush through and the extra accumulates are harmless.
  - At the final DRAIN edge, `res` <= `dsp_p` and the FSM moves to DONE.
- **DONE** lasts one cycle. `res_valid` = 1, then the FSM returns to IDLE.
- `dsp_opmode` is constant 8'h09 (X = M, Z = P, add). After CLR, P = 0 and M = 0, so this opmode is safe from the first enabled cycle.
- `res_ovf` is set on any cycle with `dsp_ce` = 1 and `dsp_carryout` = 1, and is held until the next CLR.
- Arithmetic:
  - Each product is unsigned 18x18, giving 36 bits.
  - The accumulator is 48 bits and wraps modulo 2^48; a wrap is reported through `res_ovf`.
  - No overflow is possible for `len` <= 2^12.
- `dsp_rst` = `RST` OR (state == CLR), so an external reset also clears the slice.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`, `busy`, `res_valid`, `res_ovf`, `dsp_ce` = 0.
  - `res` = 0.
  - `dsp_a`/`dsp_b`/`dsp_d` = 0.
  - `dsp_rst` = 1 while `RST` is high.
- `RST` mid-job aborts immediately. No `res_valid` is produced, and the DSP is cleared.
- Latency without stalls: with `start` sampled at the edge ending cycle 0, `res_valid` is high in cycle `len` + `DSP_LAT` + 2. Each `in_valid`-low cycle in FEED adds one cycle.
- With `len` = 0: CLR, then DRAIN, then DONE, and `res` = 0. `res_valid` is high in cycle `DSP_LAT` + 2.
- `in_valid` while not in FEED: `in_ready` = 0 and no beat is taken.
- `res` changes only at the DONE transition. `res_valid` is never high for two consecutive cycles.

## Configuration
- `DSP_MAC_PREADD_EN` defined:
  - `dsp_opmode` = 8'h19 (pre-adder on), so each beat contributes (`d_in` + `b_in`) * `a_in`.
  - The pre-add sum is truncated to 18 bits, matching the DSP.
- `DSP_MAC_PREADD_EN` undefined:
  - `dsp_d` is tied to 0 and `d_in` is unused.
  - `dsp_opmode` = 8'h09, and each beat contributes `b_in` * `a_in`.

## Test plan
- **Reset.** Assert `RST` with `in_valid` = 1 and `start` = 1. Required: all outputs at their reset values, `dsp_rst` = 1, no beat accepted.
- **Basic dot product.** `len` = 3, pairs (5,3), (12,5), (10,10), no stalls. Required: `res_valid` in cycle 8 (`DSP_LAT` = 3) with `res` = 175 and `res_ovf` = 0.
- **Backpressure.** Same job, with `in_valid` low for 2 cycles between beats 1 and 2. Required: `res` = 175, `res_valid` 2 cycles later, `dsp_ce` low during the gaps.
- **Zero length and ignored start.** `len` = 0 → `res` = 0 and `res_valid` in cycle 5. Pulse `start` during FEED of a `len` = 2 job → no effect, one result only.
- **Abort.** Assert `RST` during DRAIN of a job. Required: no `res_valid`. The next job (`len` = 1, pair (7,9)) returns 63, proving the DSP state was cleared.
- **Pre-adder (`DSP_MAC_PREADD_EN`).** `len` = 2, triples (a,b,d) = (10,10,20) and (4,1,2). Required: `res` = 312.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Purpose: dot-product controller that drives one dsp slice as a multiply-accumulator.
// Latency: res_valid is high len + DSP_LAT + 2 cycles after start; each in_valid-low FEED cycle adds one.
// Backpressure: in_valid low in FEED freezes the whole slice (dsp_ce = 0); in_ready is high only in FEED.
//
// Optional feature macro: DSP_MAC_PREADD_EN (pre-adder on, each beat contributes (d_in + b_in) * a_in).
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   start, len               job request and operand-pair count, sampled in IDLE only
//   in_valid, in_ready       operand beat handshake; a_in, b_in, d_in are the beat operands
//   busy                     high whenever the FSM is not IDLE
//   res_valid, res, res_ovf  one-cycle result strobe, held 48-bit result, sticky accumulator carry
//   dsp_a/b/d, dsp_opmode    operand and mode drive to the slice
//   dsp_ce, dsp_rst          common clock-enable and reset for every slice register
//   dsp_p, dsp_carryout      slice accumulator output and its carry-out
module dsp_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      a_in,
    input  logic [17:0]      b_in,
    input  logic [17:0]      d_in,
    output logic             busy,
    output logic             res_valid,
    output logic [47:0]      res,
    output logic             res_ovf,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [17:0]      dsp_d,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // The beat counter is reused as the drain counter; loading DSP_LAT-1 and
    // finishing at zero gives exactly DSP_LAT DRAIN cycles.
    localparam logic [LEN_W-1:0] DRAIN_LOAD = LEN_W'(DSP_LAT - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [47:0]      res_q, res_d;
    logic             res_ovf_q, res_ovf_d;
    logic             in_ready_q;
    logic             busy_q;
    logic             res_valid_q;
    logic             accept;
    logic             ce_c;

    assign accept = (state_q == ST_FEED) && in_valid;

    // Slice enable: frozen in CLR (reset wins), follows the stream in FEED,
    // free-running in DRAIN so zero products flush the pipeline.
    always_comb begin
        ce_c = 1'b0;
        case (state_q)
            ST_FEED:  ce_c = in_valid;
            ST_DRAIN: ce_c = 1'b1;
            default:  ce_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;

        // Carry-out only means something on an enabled cycle.
        if (ce_c && dsp_carryout) begin
            res_ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR;
                    cnt_d   = len;
                end
            end
            ST_CLR: begin
                res_ovf_d = 1'b0;
                if (cnt_q != '0) begin
                    state_d = ST_FEED;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_FEED: begin
                if (in_valid) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    res_d   = dsp_p;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            res_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_ovf_q   <= res_ovf_d;
            in_ready_q  <= (state_d == ST_FEED);
            busy_q      <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res       = res_q;
    assign res_ovf   = res_ovf_q;

    // External reset also clears the slice, so an abort leaves no stale P.
    assign dsp_rst = RST || (state_q == ST_CLR);
    assign dsp_ce  = ce_c;

    assign dsp_a = accept ? a_in : 18'd0;
    assign dsp_b = accept ? b_in : 18'd0;

`ifdef DSP_MAC_PREADD_EN
    assign dsp_d      = accept ? d_in : 18'd0;
    assign dsp_opmode = 8'h19;
`else
    logic unused_d_in;
    assign unused_d_in = ^d_in;
    assign dsp_d       = 18'd0;
    assign dsp_opmode  = 8'h09;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Purpose: self-checking bench for dsp_mac_sequencer with a behavioural dsp slice model.
// Latency: not applicable (testbench).
// Backpressure: stimulus inserts random and directed in_valid gaps during FEED.
module tb_dsp_mac_sequencer;

    localparam int LEN_W   = 8;
    localparam int DSP_LAT = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      a_in, b_in, d_in;
    logic             busy, res_valid, res_ovf;
    logic [47:0]      res;
    logic [17:0]      dsp_a, dsp_b, dsp_d;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce, dsp_rst;
    logic [47:0]      dsp_p;
    logic             dsp_carryout;

    dsp_mac_sequencer #(.LEN_W(LEN_W), .DSP_LAT(DSP_LAT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .d_in(d_in),
        .busy(busy), .res_valid(res_valid), .res(res), .res_ovf(res_ovf),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural slice: A/B/D register, pre-adder + multiply into M, P += M.
    logic [17:0] a_r, b_r, d_r;
    logic [35:0] m_r;
    logic [47:0] p_r;
    logic        co_r;
    logic [17:0] pre_sum;
    assign pre_sum      = dsp_opmode[4] ? 18'(b_r + d_r) : b_r;
    assign dsp_p        = p_r;
    assign dsp_carryout = co_r;
    always @(posedge CLK) begin
        if (dsp_rst) begin
            a_r <= '0; b_r <= '0; d_r <= '0; m_r <= '0; p_r <= '0; co_r <= 1'b0;
        end else if (dsp_ce) begin
            a_r <= dsp_a;
            b_r <= dsp_b;
            d_r <= dsp_d;
            m_r <= 36'(a_r) * 36'(pre_sum);
            {co_r, p_r} <= {1'b0, p_r} + {13'd0, m_r};
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Result-strobe monitor: counts results, never two in a row.
    int   rv_count = 0;
    logic rv_prev  = 1'b0;
    always @(negedge CLK) begin
        if (res_valid === 1'b1) begin
            chk("rv_single", 64'(rv_prev), 64'd0);
            rv_count++;
        end
        rv_prev = res_valid;
    end

    logic [17:0] op_a [256];
    logic [17:0] op_b [256];
    logic [17:0] op_d [256];

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            op_a[i] = 18'($urandom);
            op_b[i] = 18'($urandom);
            op_d[i] = 18'($urandom);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b, input int d);
        op_a[i] = 18'(a);
        op_b[i] = 18'(b);
        op_d[i] = 18'(d);
    endtask

    // Reference: plain sum of per-beat products, full width.
    function automatic logic [63:0] model_sum(input int n);
        logic [63:0] s = 64'd0;
        logic [17:0] m;
        for (int i = 0; i < n; i++) begin
`ifdef DSP_MAC_PREADD_EN
            m = op_b[i] + op_d[i];
`else
            m = op_b[i];
`endif
            s += 64'(op_a[i]) * 64'(m);
        end
        return s;
    endfunction

    // mode 0: no stalls, 1: random stalls, 2: two-cycle gap between beats 1 and 2
    task automatic run_job(input int n, input int mode, input bit poke_start);
        logic [63:0] exp_sum;
        int          c0;
        int          sent = 0;
        int          stalls = 0;
        int          gap_left = 2;
        bit          stall;
        bit          got = 1'b0;
        exp_sum = model_sum(n);

        @(negedge CLK);
        start = 1'b1; len = LEN_W'(n); in_valid = 1'b1; a_in = 18'($urandom);
        #1;
        chk("idle_rdy", 64'(in_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        c0 = cyc;

        @(negedge CLK);
        start = 1'b0; in_valid = 1'b1; a_in = 18'($urandom);
        #1;
        chk("clr_dsp_rst", 64'(dsp_rst), 64'd1);
        chk("clr_ce", 64'(dsp_ce), 64'd0);
        chk("clr_rdy", 64'(in_ready), 64'd0);
        chk("clr_ovf", 64'(res_ovf), 64'd0);
        chk("clr_busy", 64'(busy), 64'd1);

        while (sent < n) begin
            @(negedge CLK);
            stall = (mode == 1 && $urandom_range(0, 3) == 0) ||
                    (mode == 2 && sent == 1 && gap_left > 0);
            start = poke_start && (sent == 1);
            len   = LEN_W'($urandom_range(1, 9));
            if (stall) begin
                in_valid = 1'b0;
                a_in = 18'($urandom); b_in = 18'($urandom); d_in = 18'($urandom);
                if (mode == 2) gap_left--;
                stalls++;
                #1;
                chk("stall_rdy", 64'(in_ready), 64'd1);
                chk("stall_ce", 64'(dsp_ce), 64'd0);
                chk("stall_a", 64'(dsp_a), 64'd0);
            end else begin
                in_valid = 1'b1;
                a_in = op_a[sent]; b_in = op_b[sent]; d_in = op_d[sent];
                #1;
                chk("feed_rdy", 64'(in_ready), 64'd1);
                chk("feed_ce", 64'(dsp_ce), 64'd1);
                chk("feed_a", 64'(dsp_a), 64'(op_a[sent]));
                chk("feed_b", 64'(dsp_b), 64'(op_b[sent]));
`ifdef DSP_MAC_PREADD_EN
                chk("feed_d", 64'(dsp_d), 64'(op_d[sent]));
`else
                chk("feed_d", 64'(dsp_d), 64'd0);
`endif
                sent++;
            end
        end

        // DRAIN: junk beats offered must be refused and not reach the slice.
        for (int t = 0; t < DSP_LAT + 20 && !got; t++) begin
            @(negedge CLK);
            start = 1'b0;
            in_valid = 1'(($urandom));
            a_in = 18'($urandom); b_in = 18'($urandom);
            #1;
            if (res_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                chk("drain_rdy", 64'(in_ready), 64'd0);
                chk("drain_a", 64'(dsp_a), 64'd0);
            end
        end
        chk("rv_seen", 64'(got), 64'd1);
        if (got) begin
            chk("latency", 64'(cyc - c0), 64'(n + DSP_LAT + 2 + stalls));
            chk("res", 64'(res), 64'(exp_sum[47:0]));
            chk("res_ovf", 64'(res_ovf), 64'(exp_sum[63:48] != 16'd0));
        end

        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        chk("rv_low_after", 64'(res_valid), 64'd0);
        chk("res_hold", 64'(res), 64'(exp_sum[47:0]));
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rv_before;

        RST = 1'b1; start = 1'b1; len = 8'd5; in_valid = 1'b1;
        a_in = 18'd123; b_in = 18'd45; d_in = 18'd6;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_rdy", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rv", 64'(res_valid), 64'd0);
        chk("rst_ovf", 64'(res_ovf), 64'd0);
        chk("rst_ce", 64'(dsp_ce), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_a", 64'(dsp_a), 64'd0);
        chk("rst_b", 64'(dsp_b), 64'd0);
        chk("rst_d", 64'(dsp_d), 64'd0);
        chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
`ifdef DSP_MAC_PREADD_EN
        chk("opmode", 64'(dsp_opmode), 64'h19);
`else
        chk("opmode", 64'(dsp_opmode), 64'h09);
`endif

        @(negedge CLK);
        RST = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge CLK);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_dsp_rst", 64'(dsp_rst), 64'd0);

        // Basic dot product: 5*3 + 12*5 + 10*10 = 175.
        set_op(0, 5, 3, 0); set_op(1, 12, 5, 0); set_op(2, 10, 10, 0);
        run_job(3, 0, 1'b0);
        chk("basic_175", 64'(res), 64'd175);

        // Same job with a two-cycle gap after the first beat.
        run_job(3, 2, 1'b0);
        chk("bp_175", 64'(res), 64'd175);

        // Zero length.
        run_job(0, 0, 1'b0);
        chk("zero_len_res", 64'(res), 64'd0);

        // start pulsed during FEED is ignored: exactly one result.
        fill_random(2);
        rv_before = rv_count;
        run_job(2, 0, 1'b1);
        repeat (6) @(negedge CLK);
        #1;
        chk("poke_busy", 64'(busy), 64'd0);
        chk("poke_one_result", 64'(rv_count - rv_before), 64'd1);

        // Abort during DRAIN.
        fill_random(3);
        @(negedge CLK); start = 1'b1; len = 8'd3;
        @(negedge CLK); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            in_valid = 1'b1; a_in = op_a[i]; b_in = op_b[i]; d_in = op_d[i];
        end
        @(negedge CLK); in_valid = 1'b0;
        @(negedge CLK);
        rv_before = rv_count;
        RST = 1'b1;
        #1;
        chk("abort_dsp_rst", 64'(dsp_rst), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rdy", 64'(in_ready), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        #1;
        chk("abort_no_rv", 64'(rv_count - rv_before), 64'd0);
        chk("abort_res", 64'(res), 64'd0);
        set_op(0, 7, 9, 0);
        run_job(1, 0, 1'b0);
        chk("after_abort_63", 64'(res), 64'd63);

`ifdef DSP_MAC_PREADD_EN
        // (20+10)*10 + (2+1)*4 = 312.
        set_op(0, 10, 10, 20); set_op(1, 4, 1, 2);
        run_job(2, 0, 1'b0);
        chk("preadd_312", 64'(res), 64'd312);
`endif

        // Randomised jobs with random stalls.
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(0, 24);
            fill_random(n);
            run_job(n, $urandom_range(0, 1), 1'b0);
        end

        // Longest job the length field allows.
        fill_random(255);
        run_job(255, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
